ysyx_22040175_mem_arb: RTL and testbench
========================================

// Module: ysyx_22040175_mem_arb
// PURPOSE
//  Shares one memory bus port between instruction fetch (IF) and load/store (MEM).
//  Sits between if_stage/mem_stage and the memory bus; one outstanding transaction.
//  Data side has priority; a streak counter prevents fetch starvation.
//  Fetch flush (branch/jump redirect) drops the stale fetch response.
// PARAMETERS
//  ADDR_WIDTH  64  request address width
//  DATA_WIDTH  64  read/write data width
//  MAX_DSTREAK 4   consecutive MEM grants allowed while IF waits (>=1)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous active-high reset
//  if_req_valid   in   1   fetch request
//  if_req_addr    in   AW  fetch address
//  if_req_ready   out  1   fetch request accepted this cycle
//  if_flush       in   1   pipeline redirect; in-flight fetch response discarded
//  if_rsp_valid   out  1   fetch data valid, 1-cycle pulse
//  if_rsp_data    out  DW  fetch data
//  mem_req_valid  in   1   load/store request
//  mem_req_wen    in   1   1=store
//  mem_req_addr   in   AW  data address
//  mem_req_wdata  in   DW  store data
//  mem_req_wmask  in   8   byte strobes
//  mem_req_ready  out  1   data request accepted this cycle
//  mem_rsp_valid  out  1   load data / store ack, 1-cycle pulse
//  mem_rsp_rdata  out  DW  load data (don't-care for stores)
//  bus_req_valid  out  1   bus request
//  bus_req_wen/addr/wdata/wmask out 1/AW/DW/8  latched request fields
//  bus_req_ready  in   1   bus accepts request
//  bus_rsp_valid  in   1   bus response
//  bus_rsp_rdata  in   DW  bus read data
//  owner          out  1   0=IF, 1=MEM owns current transaction
// BEHAVIOUR
//  States: IDLE -> REQ -> WAIT -> IDLE.
//  IDLE: grant MEM if mem_req_valid, unless if_req_valid && streak==MAX_DSTREAK -> grant IF.
//   Only IF requesting -> grant IF. Grant = matching *_req_ready high same cycle (comb.,
//   only in IDLE); request fields latched; owner set; next state REQ.
//  streak: +1 per MEM grant while if_req_valid high (saturates); cleared on IF grant or
//   on MEM grant with if_req_valid low.
//  REQ: bus_req_valid=1, fields stable until bus_req_ready; on handshake -> WAIT.
//  WAIT: on bus_rsp_valid register data into owner's *_rsp_data, pulse owner's
//   *_rsp_valid next cycle, -> IDLE. A new grant may occur in the cycle rsp_valid pulses.
//  Latency (zero-wait bus): grant N, bus handshake N+1, bus_rsp N+2, rsp_valid N+3.
//  Flush: if_flush while owner=IF in REQ/WAIT sets drop; response consumed, if_rsp_valid
//   stays 0; drop cleared on return to IDLE. if_flush in IDLE or owner=MEM: no effect.
//   if_flush same cycle as IF grant: grant proceeds, drop set.
//  bus_rsp_valid in IDLE/REQ: ignored. *_req_ready never high outside IDLE.
//  Reset (any time, incl. mid-transaction): state IDLE, streak=0, drop=0, owner=0,
//   all valid/ready outputs 0, latched fields and rsp data 0; in-flight txn abandoned.
// TESTING
//  IF only, addr 0x80000000, bus ready=1, rsp 0x00100073 at N+2 -> if_rsp_valid N+3, data matches.
//  IF+MEM both valid in IDLE -> mem_req_ready=1, if_req_ready=0, owner=1, bus_req_addr=MEM addr.
//  MEM and IF held valid continuously -> 4 MEM grants then 1 IF grant, pattern repeats.
//  Store wen=1 wmask=0x0F wdata=0xDEADBEEF, bus_req_ready low 3 cycles -> fields stable, mem_rsp_valid after ack.
//  if_flush in WAIT for IF txn -> rsp arrives, if_rsp_valid stays 0, next IF grant served normally.
//  rst asserted in WAIT -> outputs 0 immediately; late bus_rsp_valid after release ignored.

Source files
------------

// File: rtl/ysyx_22040175_mem_arb_if.sv
// ysyx_22040175_mem_arb_if: fetch, load/store and memory-bus signals around the arbiter
interface ysyx_22040175_mem_arb_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  if_req_ready;
    logic                  if_flush;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rsp_data;
    logic                  mem_req_valid;
    logic                  mem_req_wen;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [7:0]            mem_req_wmask;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;
    logic                  bus_req_valid;
    logic                  bus_req_wen;
    logic [ADDR_WIDTH-1:0] bus_req_addr;
    logic [DATA_WIDTH-1:0] bus_req_wdata;
    logic [7:0]            bus_req_wmask;
    logic                  bus_req_ready;
    logic                  bus_rsp_valid;
    logic [DATA_WIDTH-1:0] bus_rsp_rdata;
    logic                  owner;
    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask,
        output owner
    );
    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wmask,
        input  owner
    );
endinterface

// File: rtl/ysyx_22040175_mem_arb.sv
// ysyx_22040175_mem_arb: one-outstanding memory bus arbiter, data priority with fetch anti-starvation and flush drop
module ysyx_22040175_mem_arb #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_DSTREAK = 4
) (
    input logic clk,
    input logic rst,
    ysyx_22040175_mem_arb_if.slave io
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t                r_state;
    logic [SW-1:0]         r_streak;
    logic                  r_drop, r_owner, r_bus_req_valid, r_wen, r_if_rsp_valid, r_mem_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_if_rsp_data, r_mem_rsp_data;
    logic [7:0]            r_wmask;
    logic                  w_idle, w_grant_if, w_grant_mem, w_flush_if;
    assign w_idle      = r_state == IDLE && !rst;
    assign w_grant_if  = w_idle && io.if_req_valid && (!io.mem_req_valid || r_streak == SW'(MAX_DSTREAK));
    assign w_grant_mem = w_idle && io.mem_req_valid && !w_grant_if;
    assign w_flush_if  = !r_owner && io.if_flush;
    assign io.if_req_ready  = w_grant_if;
    assign io.mem_req_ready = w_grant_mem;
    assign io.if_rsp_valid  = r_if_rsp_valid;
    assign io.if_rsp_data   = r_if_rsp_data;
    assign io.mem_rsp_valid = r_mem_rsp_valid;
    assign io.mem_rsp_rdata = r_mem_rsp_data;
    assign io.bus_req_valid = r_bus_req_valid;
    assign io.bus_req_wen   = r_wen;
    assign io.bus_req_addr  = r_addr;
    assign io.bus_req_wdata = r_wdata;
    assign io.bus_req_wmask = r_wmask;
    assign io.owner         = r_owner;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_streak        <= '0;
            r_drop          <= 1'b0;
            r_owner         <= 1'b0;
            r_bus_req_valid <= 1'b0;
            r_wen           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_if_rsp_valid  <= 1'b0;
            r_if_rsp_data   <= '0;
            r_mem_rsp_valid <= 1'b0;
            r_mem_rsp_data  <= '0;
        end else begin
            r_if_rsp_valid  <= 1'b0;
            r_mem_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_grant_if || w_grant_mem) begin
                    r_state         <= REQ;
                    r_bus_req_valid <= 1'b1;
                    r_owner         <= w_grant_mem;
                    r_wen           <= w_grant_mem && io.mem_req_wen;
                    r_addr          <= w_grant_mem ? io.mem_req_addr : io.if_req_addr;
                    r_wdata         <= w_grant_mem ? io.mem_req_wdata : '0;
                    r_wmask         <= w_grant_mem ? io.mem_req_wmask : '0;
                    r_drop          <= w_grant_if && io.if_flush;
                    // streak only grows while fetch is actually being held off
                    r_streak        <= (w_grant_mem && io.if_req_valid) ?
                                       r_streak + SW'(r_streak != SW'(MAX_DSTREAK)) : '0;
                end
                REQ: begin
                    r_drop <= r_drop || w_flush_if;
                    if (io.bus_req_ready) begin
                        r_state         <= WAIT;
                        r_bus_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    r_drop <= r_drop || w_flush_if;
                    if (io.bus_rsp_valid) begin
                        r_state         <= IDLE;
                        r_drop          <= 1'b0;
                        r_mem_rsp_valid <= r_owner;
                        r_if_rsp_valid  <= !r_owner && !(r_drop || io.if_flush);
                        if (r_owner) r_mem_rsp_data <= io.bus_rsp_rdata;
                        else if (!(r_drop || io.if_flush)) r_if_rsp_data <= io.bus_rsp_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040175_mem_arb.sv
// tb_ysyx_22040175_mem_arb: scoreboard bench for the fetch/load-store memory bus arbiter
module tb_ysyx_22040175_mem_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    typedef struct packed {logic mem; logic chk; logic [63:0] data;} exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] mon_d;
    ysyx_22040175_mem_arb_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bif ();
    ysyx_22040175_mem_arb #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst), .io(bif)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst && (bif.if_rsp_valid || bif.mem_rsp_valid)) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL rsp_unexpected if_rsp_valid=%0b mem_rsp_valid=%0b required none", bif.if_rsp_valid, bif.mem_rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                mon_d = bif.mem_rsp_valid ? bif.mem_rsp_rdata : bif.if_rsp_data;
                if (bif.mem_rsp_valid !== mon_e.mem || (mon_e.chk && mon_d !== mon_e.data)) begin
                    bad = bad + 1;
                    $display("FAIL rsp_scoreboard got mem=%0b data=%h required mem=%0b data=%h", bif.mem_rsp_valid, mon_d, mon_e.mem, mon_e.data);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic bus_serve(input int stall, input logic [63:0] rdata);
        int n = 0;
        while (bif.bus_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL bus_req_timeout got=0 required=1");
            return;
        end
        repeat (stall) tick();
        bif.bus_req_ready = 1'b1;
        tick();
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_rdata = rdata;
        tick();
        bif.bus_rsp_valid = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bif.if_req_valid = 1'b1;
        bif.mem_req_valid = 1'b1;
        repeat (2) tick();
        total += 4;
        if (bif.if_req_ready !== 1'b0) begin bad++; $display("FAIL rst_if_ready got=%b required=0", bif.if_req_ready); end
        if (bif.mem_req_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b required=0", bif.mem_req_ready); end
        if ({bif.bus_req_valid, bif.owner, bif.if_rsp_valid, bif.mem_rsp_valid} !== 4'b0) begin
            bad++; $display("FAIL rst_flags got=%b required=0000", {bif.bus_req_valid, bif.owner, bif.if_rsp_valid, bif.mem_rsp_valid});
        end
        if (bif.bus_req_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got=%h required=0", bif.bus_req_addr); end
        bif.if_req_valid = 1'b0;
        bif.mem_req_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask
    task automatic test_if_fetch;
        bif.if_req_valid = 1'b1;
        bif.if_req_addr = 64'h8000_0000;
        #1;
        total += 2;
        if (bif.if_req_ready !== 1'b1) begin bad++; $display("FAIL fetch_if_ready got=%b required=1", bif.if_req_ready); end
        if (bif.mem_req_ready !== 1'b0) begin bad++; $display("FAIL fetch_mem_ready got=%b required=0", bif.mem_req_ready); end
        sb.push_back({1'b0, 1'b1, 64'h0010_0073});
        tick();
        bif.if_req_valid = 1'b0;
        total += 2;
        if ({bif.bus_req_valid, bif.owner, bif.bus_req_wen} !== 3'b100) begin
            bad++; $display("FAIL fetch_req_flags got=%b required=100", {bif.bus_req_valid, bif.owner, bif.bus_req_wen});
        end
        if (bif.bus_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL fetch_addr got=%h required=80000000", bif.bus_req_addr); end
        bus_serve(0, 64'h0010_0073);
        total += 2;
        if (bif.if_rsp_valid !== 1'b1) begin bad++; $display("FAIL fetch_latency got=%b required=1", bif.if_rsp_valid); end
        if (bif.if_rsp_data !== 64'h0010_0073) begin bad++; $display("FAIL fetch_data got=%h required=00100073", bif.if_rsp_data); end
        tick();
    endtask
    task automatic test_priority;
        bif.if_req_valid = 1'b1;
        bif.if_req_addr = 64'h1000;
        bif.mem_req_valid = 1'b1;
        bif.mem_req_wen = 1'b0;
        bif.mem_req_addr = 64'h2000;
        #1;
        total++;
        if ({bif.mem_req_ready, bif.if_req_ready} !== 2'b10) begin
            bad++; $display("FAIL prio_ready got=%b required=10", {bif.mem_req_ready, bif.if_req_ready});
        end
        sb.push_back({1'b1, 1'b1, 64'hA5A5});
        tick();
        bif.mem_req_valid = 1'b0;
        total += 2;
        if (bif.owner !== 1'b1) begin bad++; $display("FAIL prio_owner got=%b required=1", bif.owner); end
        if (bif.bus_req_addr !== 64'h2000) begin bad++; $display("FAIL prio_addr got=%h required=2000", bif.bus_req_addr); end
        bus_serve(0, 64'hA5A5);
        total++;
        if (bif.if_req_ready !== 1'b1) begin bad++; $display("FAIL prio_if_next got=%b required=1", bif.if_req_ready); end
        sb.push_back({1'b0, 1'b1, 64'h5A5A});
        tick();
        bif.if_req_valid = 1'b0;
        total++;
        if (bif.bus_req_addr !== 64'h1000) begin bad++; $display("FAIL prio_if_addr got=%h required=1000", bif.bus_req_addr); end
        bus_serve(0, 64'h5A5A);
        tick();
    endtask
    task automatic test_streak;
        logic em;
        bif.if_req_valid = 1'b1;
        bif.if_req_addr = 64'h8000_0100;
        bif.mem_req_valid = 1'b1;
        bif.mem_req_wen = 1'b0;
        bif.mem_req_addr = 64'h6000;
        for (int i = 0; i < 10; i++) begin
            #1;
            em = (i % 5) != 4;
            total++;
            if ({bif.mem_req_ready, bif.if_req_ready} !== {em, !em}) begin
                bad++; $display("FAIL streak_grant%0d got=%b required=%b", i, {bif.mem_req_ready, bif.if_req_ready}, {em, !em});
            end
            sb.push_back({em, 1'b1, 64'h5000 + 64'(i)});
            tick();
            bus_serve(0, 64'h5000 + 64'(i));
        end
        bif.if_req_valid = 1'b0;
        bif.mem_req_valid = 1'b0;
        tick();
    endtask
    task automatic test_store;
        bif.mem_req_valid = 1'b1;
        bif.mem_req_wen = 1'b1;
        bif.mem_req_addr = 64'h3000;
        bif.mem_req_wdata = 64'hDEAD_BEEF;
        bif.mem_req_wmask = 8'h0F;
        #1;
        total++;
        if (bif.mem_req_ready !== 1'b1) begin bad++; $display("FAIL store_ready got=%b required=1", bif.mem_req_ready); end
        sb.push_back({1'b1, 1'b0, 64'h0});
        tick();
        bif.mem_req_valid = 1'b0;
        bif.mem_req_wen = 1'b0;
        bif.mem_req_addr = 64'h0;
        bif.mem_req_wdata = 64'h0;
        bif.mem_req_wmask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bif.bus_req_valid, bif.bus_req_wen, bif.bus_req_wmask, bif.bus_req_wdata, bif.bus_req_addr} !==
                {1'b1, 1'b1, 8'h0F, 64'hDEAD_BEEF, 64'h3000}) begin
                bad++; $display("FAIL store_stable%0d got=%b %b %h %h %h required=1 1 0f deadbeef 3000", i,
                    bif.bus_req_valid, bif.bus_req_wen, bif.bus_req_wmask, bif.bus_req_wdata, bif.bus_req_addr);
            end
            tick();
        end
        bus_serve(0, 64'h0);
        total++;
        if (bif.mem_rsp_valid !== 1'b1) begin bad++; $display("FAIL store_ack got=%b required=1", bif.mem_rsp_valid); end
        tick();
    endtask
    task automatic test_flush;
        bif.if_req_valid = 1'b1;
        bif.if_req_addr = 64'h8000_0004;
        #1;
        tick();
        bif.if_req_valid = 1'b0;
        bif.bus_req_ready = 1'b1;
        tick();
        bif.bus_req_ready = 1'b0;
        bif.if_flush = 1'b1;
        tick();
        bif.if_flush = 1'b0;
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_rdata = 64'hBAD;
        tick();
        bif.bus_rsp_valid = 1'b0;
        total++;
        if (bif.if_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_wait got=%b required=0", bif.if_rsp_valid); end
        bif.if_req_valid = 1'b1;
        bif.if_flush = 1'b1;
        #1;
        total++;
        if (bif.if_req_ready !== 1'b1) begin bad++; $display("FAIL flush_grant_ready got=%b required=1", bif.if_req_ready); end
        tick();
        bif.if_req_valid = 1'b0;
        bif.if_flush = 1'b0;
        bus_serve(0, 64'hBAD2);
        total++;
        if (bif.if_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_at_grant got=%b required=0", bif.if_rsp_valid); end
        bif.if_req_valid = 1'b1;
        bif.if_req_addr = 64'h8000_0008;
        #1;
        sb.push_back({1'b0, 1'b1, 64'h13});
        tick();
        bif.if_req_valid = 1'b0;
        bus_serve(0, 64'h13);
        total++;
        if (bif.if_rsp_valid !== 1'b1) begin bad++; $display("FAIL flush_recover got=%b required=1", bif.if_rsp_valid); end
        tick();
    endtask
    task automatic test_reset_mid;
        bif.mem_req_valid = 1'b1;
        bif.mem_req_wen = 1'b0;
        bif.mem_req_addr = 64'h4000;
        #1;
        tick();
        bif.mem_req_valid = 1'b0;
        bif.bus_req_ready = 1'b1;
        tick();
        bif.bus_req_ready = 1'b0;
        total++;
        if (bif.owner !== 1'b1) begin bad++; $display("FAIL rmid_owner_pre got=%b required=1", bif.owner); end
        #2;
        rst = 1'b1;
        bif.mem_req_valid = 1'b1;
        #1;
        total += 3;
        if (bif.owner !== 1'b0) begin bad++; $display("FAIL rmid_owner got=%b required=0", bif.owner); end
        if (bif.bus_req_addr !== 64'h0) begin bad++; $display("FAIL rmid_addr got=%h required=0", bif.bus_req_addr); end
        if (bif.mem_req_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b required=0", bif.mem_req_ready); end
        tick();
        bif.mem_req_valid = 1'b0;
        rst = 1'b0;
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_rdata = 64'hFEED;
        tick();
        bif.bus_rsp_valid = 1'b0;
        total++;
        if ({bif.mem_rsp_valid, bif.if_rsp_valid} !== 2'b00) begin
            bad++; $display("FAIL rmid_late_rsp got=%b required=00", {bif.mem_rsp_valid, bif.if_rsp_valid});
        end
        bif.if_req_valid = 1'b1;
        #1;
        total++;
        if (bif.if_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b required=1", bif.if_req_ready); end
        bif.if_req_valid = 1'b0;
        tick();
    endtask
    initial begin
        rst = 1'b1;
        bif.if_req_valid = 1'b0;
        bif.if_req_addr = '0;
        bif.if_flush = 1'b0;
        bif.mem_req_valid = 1'b0;
        bif.mem_req_wen = 1'b0;
        bif.mem_req_addr = '0;
        bif.mem_req_wdata = '0;
        bif.mem_req_wmask = '0;
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_rdata = '0;
        test_reset();
        test_if_fetch();
        test_priority();
        test_streak();
        test_store();
        test_flush();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d required=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
